// File: rtl/q2_datapath.sv
// Q2 datapath: A/X/P/S registers, wired-AND bus emulation and a serial
// shift engine that steps X one bit per cycle under a busy/done handshake.
module q2_datapath #(
  parameter int unsigned       WIDTH   = 12,
  parameter logic [WIDTH-1:0]  RESET_P = '0,
  parameter int unsigned       CNT_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dbus_in,
  output logic [WIDTH-1:0] dbus_out,
  output logic             dbus_oe,
  output logic [WIDTH-1:0] abus_out,
  output logic             abus_oe,
  input  logic             wra,
  input  logic             rda,
  input  logic             wrx,
  input  logic [1:0]       xsel,
  input  logic             rdx,
  input  logic             wrp,
  input  logic             incp,
  input  logic             rdp,
  input  logic             sw,
  input  logic             dep,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             rsts,
  input  logic             wrs,
  input  logic             sin,
  input  logic             shift_start,
  input  logic             shift_dir,
  input  logic [CNT_W-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] aout,
  output logic [WIDTH-1:0] xout,
  output logic [WIDTH-1:0] pout,
  output logic             sout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, x_q, p_q;
  logic             s_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;

  logic [WIDTH-1:0] x_shifted;
  logic             shift_bit;
  logic [WIDTH-1:0] x_load;
  logic             panel_drive;

  // Next-state logic for the shift sequencer
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (shift_start) state_nx = (shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register; busy/done are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == SHIFT);
      done  <= (state_nx == DONE);
    end
  end

  // One-bit shift of X with zero fill; shift_bit is the bit leaving X
  always_comb begin
    x_shifted = x_q;
    shift_bit = 1'b0;
    if (dir_q) begin
      x_shifted = {1'b0, x_q[WIDTH-1:1]};
      shift_bit = x_q[0];
    end else begin
      x_shifted = {x_q[WIDTH-2:0], 1'b0};
      shift_bit = x_q[WIDTH-1];
    end
  end

  always_comb begin
    x_load = x_q;
    case (xsel)
      2'd0:    x_load = '0;
      2'd1:    x_load = p_q;
      2'd2:    x_load = dbus_in;
      default: x_load = x_q;
    endcase
  end

  // Architectural registers; the shift engine owns X and S while shifting
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      x_q   <= '0;
      p_q   <= RESET_P;
      s_q   <= 1'b0;
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else begin
      if (wra) a_q <= dbus_in;

      if (wrp)       p_q <= x_q;
      else if (incp) p_q <= p_q + WIDTH'(1);

      if (state == SHIFT) x_q <= x_shifted;
      else if (wrx)       x_q <= x_load;

      if (rsts)                s_q <= 1'b0;
      else if (state == SHIFT) s_q <= shift_bit;
      else if (wrs)            s_q <= sin;

      if (state == IDLE && shift_start) begin
        cnt_q <= shamt;
        dir_q <= shift_dir;
      end else if (state == SHIFT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Open-drain emulation: inactive drivers contribute all-ones
  assign panel_drive = dep & sw;
  assign dbus_oe     = rda | panel_drive;
  assign dbus_out    = (rda ? a_q : '1) & (panel_drive ? sw_data : '1);
  assign abus_oe     = rdx | rdp;
  assign abus_out    = (rdx ? x_q : '1) & (rdp ? p_q : '1);

  assign aout = a_q;
  assign xout = x_q;
  assign pout = p_q;
  assign sout = s_q;

endmodule

// File: doc/q2_datapath.md
Name: q2_datapath

Overview:
Parametrised, fully synchronous successor to the per-bit Q2 slice. Holds the A, X and P registers at WIDTH bits plus a single S status bit, all in one clock domain. Open-drain buses are emulated as data/output-enable pairs with wired-AND merging. Adds a multi-cycle barrel-free shift engine that moves X left or right by a programmable count, with a busy/done handshake, capturing the last shifted-out bit in S.

Parameters:
WIDTH, 12, datapath width of A, X, P and the buses
RESET_P, 0, value loaded into P on reset
CNT_W, $clog2(WIDTH), width of the shift count (derived; do not override)

Ports:
clk  in  1  single system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
dbus_in  in  WIDTH  resolved data-bus value
dbus_out  out  WIDTH  data-bus drive value (wired-AND of all local drivers)
dbus_oe  out  1  data-bus drive enable
abus_out  out  WIDTH  address-bus drive value (wired-AND of all local drivers)
abus_oe  out  1  address-bus drive enable
wra  in  1  A <= dbus_in
rda  in  1  drive A onto dbus
wrx  in  1  load X per xsel
xsel  in  2  X source: 0 zero, 1 P, 2 dbus_in, 3 hold
rdx  in  1  drive X onto abus
wrp  in  1  P <= X (jump)
incp  in  1  P <= P+1
rdp  in  1  drive P onto abus
sw  in  1  front-panel mode
dep  in  1  panel deposit: drive sw_data onto dbus (only when sw=1)
sw_data  in  WIDTH  panel switch value
rsts  in  1  clear S
wrs  in  1  S <= sin
sin  in  1  S load value
shift_start  in  1  start shift of X
shift_dir  in  1  0 left (toward MSB), 1 right
shamt  in  CNT_W  shift count, 0..WIDTH-1
busy  out  1  shift engine active
done  out  1  one-cycle completion pulse
aout  out  WIDTH  A lamps
xout  out  WIDTH  X lamps
pout  out  WIDTH  P lamps
sout  out  1  S lamp

Behaviour:
- Reset (rst=0 at a rising edge): A=0, X=0, P=RESET_P, S=0, FSM=IDLE, busy=0, done=0. Reset wins over every other input and aborts any shift in progress.
- Buses are combinational from registers and strobes:
  - dbus_oe = rda | (dep & sw); dbus_out = AND of the active drivers (A, sw_data); all-ones when idle.
  - abus_oe = rdx | rdp; abus_out = AND of the active drivers (X, P); all-ones when idle.
- A: wra loads dbus_in at the clock edge.
- P: wrp has priority over incp. incp wraps modulo 2^WIDTH (all-ones -> 0). wrp and incp are not gated by sw.
- X: wrx loads per xsel; xsel=3 holds. wrx is ignored while busy=1 (the shift owns X).
- FSM states IDLE, SHIFT, DONE:
  - IDLE: shift_start=1 latches shift_dir and cnt=shamt. Next state is SHIFT if shamt!=0, else DONE. If wrx and shift_start are both high in IDLE, wrx loads X on that edge and the shift then operates on the new value.
  - SHIFT: busy=1. Each cycle X shifts one bit (fill 0), S <= bit shifted out, cnt--. When cnt==1 at the edge, next state is DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
  - shift_start is ignored outside IDLE.
- Latency for shamt=n>0: busy high for n cycles starting the cycle after the start edge; done follows in cycle n+1. For n=0: done in the cycle after start, X and S unchanged, busy never asserts.
- S priority per edge: rsts > shift update > wrs.
- aout/xout/pout/sout are direct register outputs.

Test Plan:
- Reset: hold rst=0 one edge with wra=1 and dbus_in=0xFFF -> A=0, X=0, P=RESET_P, S=0, busy=0, done=0.
- P wrap and jump: P=0xFFF, incp -> P=0x000. Then X=0x123 with wrp=1 and incp=1 on the same edge -> P=0x123.
- Bus wired-AND: A=0x0F0 with rda=1, sw=1, dep=1, sw_data=0x3C3 -> dbus_oe=1, dbus_out=0x0C0. X=0xAAA, P=0x0FF, rdx=rdp=1 -> abus_out=0x0AA.
- Left shift: X=0x801, shamt=3, dir=0 -> busy for 3 cycles, done in the 4th; X=0x008, S=0. Mid-shift wrx with xsel=0 is ignored.
- Right shift and zero count: X=0x005, shamt=1, dir=1 -> X=0x002, S=1. Then shamt=0 -> done in the next cycle, X=0x002 unchanged, busy stays 0.
- Reset mid-shift: start shamt=5, drive rst=0 on the 2nd busy cycle -> FSM=IDLE, busy=0, no done pulse, X=0; a new shift_start the following cycle is accepted.
